vector_lane_seq_alu: RTL and testbench

- Vector execution stage placed directly downstream of the vector register file.
- Consumes the two 5-lane operand vectors read at ra1/ra2 and returns the 5-lane result plus write-back controls (size, destination, enable) to the register file write port.
- Uses one shared 32-bit integer ALU stepped across lanes, one lane per cycle, with a start/done handshake.

---
 rtl/vector_lane_seq_alu.sv | 81 ++++++++
 tb/tb_vector_lane_seq_alu.sv | 117 +++++++++++
 2 files changed

// File: rtl/vector_lane_seq_alu.sv
// vector_lane_seq_alu: sequential 5-lane vector ALU, one lane per cycle, start/done handshake
module vector_lane_seq_alu #(
   parameter int WIDTH = 32,
   parameter int LANES = 5
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [2:0]             vector_size,
   input  logic [2:0]             op,
   input  logic [3:0]             wa,
   input  logic [LANES*WIDTH-1:0] a_vec,
   input  logic [LANES*WIDTH-1:0] b_vec,
   output logic [LANES*WIDTH-1:0] y_vec,
   output logic [2:0]             wb_size,
   output logic [3:0]             wb_wa,
   output logic                   wb_en,
   output logic                   busy,
   output logic                   done
);
   localparam logic [1:0] IDLE = 2'd0, EXEC = 2'd1, FIN = 2'd2;
   localparam logic [2:0] MAX_SIZE = 3'(LANES);

   logic [1:0] state;
   logic [2:0] cnt, op_q, clamp;
   logic [LANES-1:0][WIDTH-1:0] a_q, b_q, y_q;
   logic [WIDTH-1:0] la, lb, res;

   assign clamp = vector_size > MAX_SIZE ? MAX_SIZE : vector_size;
   assign la = a_q[cnt];
   assign lb = b_q[cnt];
   assign y_vec = y_q;
   assign busy = state != IDLE;
   assign done = state == FIN;
   assign wb_en = done && wb_size != 3'd0;

   always_comb begin
      case (op_q)
         3'b000:  res = la + lb;
         3'b001:  res = la - lb;
         3'b010:  res = la * lb;
         3'b011:  res = la & lb;
         3'b100:  res = la | lb;
         3'b101:  res = la ^ lb;
         3'b110:  res = $signed(la) > $signed(lb) ? la : lb;
         default: res = $signed(la) < $signed(lb) ? la : lb;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         y_q     <= '0;
         wb_size <= '0;
         wb_wa   <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               a_q     <= a_vec;
               b_q     <= b_vec;
               op_q    <= op;
               wb_wa   <= wa;
               wb_size <= clamp;
               y_q     <= '0;
               cnt     <= '0;
               state   <= clamp != 3'd0 ? EXEC : FIN;
            end
            EXEC: begin
               y_q[cnt] <= res;
               cnt      <= cnt + 3'd1;
               if (cnt == wb_size - 3'd1) state <= FIN;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_vector_lane_seq_alu.sv
// tb_vector_lane_seq_alu: directed self-checking bench for vector_lane_seq_alu
module tb_vector_lane_seq_alu;
   logic clk = 0, reset = 1, start = 0;
   logic [2:0] vector_size = 0, op = 0, wb_size;
   logic [3:0] wa = 0, wb_wa;
   logic [159:0] a_vec = 0, b_vec = 0, y_vec;
   logic wb_en, busy, done;
   int n_cmp = 0, n_bad = 0;

   localparam logic [159:0] A2   = {5{32'd2}};
   localparam logic [159:0] B3_7 = {32'd7, 32'd6, 32'd5, 32'd4, 32'd3};
   localparam logic [159:0] AMM  = {96'd0, 32'd5, 32'h8000_0000};
   localparam logic [159:0] BMM  = {96'd0, 32'd7, 32'd1};

   vector_lane_seq_alu dut (
      .clk(clk), .reset(reset), .start(start), .vector_size(vector_size), .op(op), .wa(wa),
      .a_vec(a_vec), .b_vec(b_vec), .y_vec(y_vec), .wb_size(wb_size), .wb_wa(wb_wa),
      .wb_en(wb_en), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic launch(input logic [2:0] o, input logic [2:0] sz, input logic [3:0] w,
                         input logic [159:0] a, input logic [159:0] b);
      @(negedge clk);
      op = o; vector_size = sz; wa = w; a_vec = a; b_vec = b; start = 1;
      @(posedge clk); #1;
      start = 0; a_vec = {5{32'hDEAD_BEEF}}; b_vec = {5{32'h1234_5678}}; op = ~o; wa = ~w;
   endtask

   task automatic wait_done(input string tag, input int n_exp);
      int n = 0;
      while (!done && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check({tag, ".cycles"}, 160'(n), 160'(n_exp));
   endtask

   task automatic run(input string tag, input logic [2:0] o, input logic [2:0] sz, input logic [3:0] w,
                      input logic [159:0] a, input logic [159:0] b, input logic [159:0] y_exp,
                      input int n_exp, input logic [2:0] sz_exp);
      launch(o, sz, w, a, b);
      wait_done(tag, n_exp);
      check({tag, ".y"}, y_vec, y_exp);
      check({tag, ".wb_size"}, 160'(wb_size), 160'(sz_exp));
      check({tag, ".wb_wa"}, 160'(wb_wa), 160'(w));
      check({tag, ".wb_en"}, 160'(wb_en), 160'(sz_exp != 0));
      check({tag, ".busy"}, 160'(busy), 160'(1));
      @(posedge clk); #1;
      check({tag, ".done_fall"}, 160'({done, wb_en, busy}), 160'(0));
      check({tag, ".y_hold"}, y_vec, y_exp);
   endtask

   initial begin
      #12;
      check("rst.ctl", 160'({done, wb_en, busy}), 160'(0));
      check("rst.y", y_vec, 160'(0));
      check("rst.wb", 160'({wb_size, wb_wa}), 160'(0));
      @(negedge clk); reset = 0;

      run("add5", 3'b000, 3'd5, 4'hA, A2, B3_7, {32'd9, 32'd8, 32'd7, 32'd6, 32'd5}, 5, 3'd5);
      run("mul3", 3'b010, 3'd3, 4'h3, A2, B3_7, {64'd0, 32'd10, 32'd8, 32'd6}, 3, 3'd3);
      run("sub2", 3'b001, 3'd2, 4'h5, A2, B3_7, {96'd0, 32'hFFFF_FFFE, 32'hFFFF_FFFF}, 2, 3'd2);
      run("min2", 3'b111, 3'd2, 4'h6, AMM, BMM, {96'd0, 32'd5, 32'h8000_0000}, 2, 3'd2);
      run("max2", 3'b110, 3'd2, 4'h7, AMM, BMM, {96'd0, 32'd7, 32'd1}, 2, 3'd2);
      run("eor1", 3'b101, 3'd1, 4'h8, {128'd0, 32'hF0F0_F0F0}, {128'd0, 32'hFF00_FF00},
          {128'd0, 32'h0FF0_0FF0}, 1, 3'd1);
      run("and1", 3'b011, 3'd1, 4'h9, {128'd0, 32'hF0F0_F0F0}, {128'd0, 32'hFF00_FF00},
          {128'd0, 32'hF000_F000}, 1, 3'd1);
      run("orr1", 3'b100, 3'd1, 4'hB, {128'd0, 32'hF0F0_F0F0}, {128'd0, 32'hFF00_FF00},
          {128'd0, 32'hFFF0_FFF0}, 1, 3'd1);
      run("size0", 3'b000, 3'd0, 4'hC, A2, B3_7, 160'd0, 0, 3'd0);
      run("size7", 3'b000, 3'd7, 4'hD, A2, B3_7, {32'd9, 32'd8, 32'd7, 32'd6, 32'd5}, 5, 3'd5);

      // start held high through EXEC and FIN with new operands: only accepted once back in IDLE
      @(negedge clk);
      op = 3'b010; vector_size = 3'd3; wa = 4'h2; a_vec = A2; b_vec = B3_7; start = 1;
      @(posedge clk); #1;
      op = 3'b000; vector_size = 3'd5; wa = 4'hE; a_vec = {5{32'd100}}; b_vec = {32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
      wait_done("ign", 3);
      check("ign.y", y_vec, {64'd0, 32'd10, 32'd8, 32'd6});
      check("ign.wa", 160'({wb_wa, wb_size}), 160'({4'h2, 3'd3}));
      @(posedge clk); #1;
      check("ign.idle", 160'({busy, done}), 160'(0));
      @(posedge clk); #1;
      start = 0;
      check("ign.accept", 160'(busy), 160'(1));
      wait_done("ign2", 5);
      check("ign2.y", y_vec, {32'd105, 32'd104, 32'd103, 32'd102, 32'd101});
      check("ign2.wa", 160'({wb_wa, wb_size}), 160'({4'hE, 3'd5}));
      @(posedge clk); #1;

      // asynchronous reset mid-EXEC after two lanes have been written
      launch(3'b000, 3'd5, 4'h4, A2, B3_7);
      @(posedge clk); #1;
      @(posedge clk); #2;
      check("arst.pre", y_vec, {96'd0, 32'd6, 32'd5});
      reset = 1; #1;
      check("arst.ctl", 160'({busy, done, wb_en}), 160'(0));
      check("arst.y", y_vec, 160'd0);
      check("arst.wb", 160'({wb_size, wb_wa}), 160'(0));
      @(negedge clk); reset = 0;
      run("post", 3'b000, 3'd5, 4'h1, A2, B3_7, {32'd9, 32'd8, 32'd7, 32'd6, 32'd5}, 5, 3'd5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
